// File: rtl/egg_timer_if.sv
// Egg timer controller bus.
// Carries the time-base input and the button pulses into the controller,
// and the registered time, phase and alarm status back out.
//   tick_in   : divider square wave; each rising edge is one tick
//   btn_*     : one-cycle debounced button pulses (min, sec, start, clear)
//   minutes   : 0..MAX_MINUTES
//   seconds   : 0..59
//   running   : high only in RUN
//   alarm     : high only in ALARM
//   state     : IDLE=0, RUN=1, PAUSE=2, ALARM=3
interface egg_timer_if;
  logic       tick_in;
  logic       btn_min;
  logic       btn_sec;
  logic       btn_start;
  logic       btn_clear;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output tick_in, btn_min, btn_sec, btn_start, btn_clear,
    input  minutes, seconds, running, alarm, state
  );

  modport slave (
    input  tick_in, btn_min, btn_sec, btn_start, btn_clear,
    output minutes, seconds, running, alarm, state
  );
endinterface

// File: rtl/egg_timer_controller.sv
// Egg timer countdown sequencer.
// Detects rising edges of the divided time base as one-second ticks and runs
// a minutes:seconds countdown through IDLE / RUN / PAUSE / ALARM.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : egg_timer_if slave (tick/buttons in, time/status out)
// All outputs come straight from registers.
module egg_timer_controller #(
  parameter int MAX_MINUTES = 99,
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  egg_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ALARM = 2'd3} state_t;

  localparam logic [6:0] MAX_M = 7'(MAX_MINUTES);
  localparam logic [7:0] A_TKS = 8'(ALARM_TICKS);

  state_t     state_q, state_n;
  logic [6:0] min_q, min_n;
  logic [5:0] sec_q, sec_n;
  logic [7:0] cnt_q, cnt_n;
  logic       tick_q;
  logic       running_q, alarm_q;
  logic       tick_pulse;

  assign tick_pulse = bus.tick_in & ~tick_q;

  always_comb begin
    state_n = state_q;
    min_n   = min_q;
    sec_n   = sec_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.btn_clear) begin
          min_n = '0;
          sec_n = '0;
        end else if (bus.btn_start) begin
          if (min_q != '0 || sec_q != '0) state_n = RUN;
        end else begin
          if (bus.btn_min) min_n = (min_q == MAX_M) ? 7'd0 : min_q + 7'd1;
          if (bus.btn_sec) sec_n = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        end
      end
      RUN: begin
        if (bus.btn_clear) begin
          state_n = IDLE;
          min_n   = '0;
          sec_n   = '0;
        end else if (bus.btn_start) begin
          // A tick coinciding with pause is dropped on purpose.
          state_n = PAUSE;
        end else if (tick_pulse) begin
          if (sec_q != '0) begin
            sec_n = sec_q - 6'd1;
          end else begin
            min_n = min_q - 7'd1;
            sec_n = 6'd59;
          end
          // 0:01 -> 0:00 expires in the same update.
          if (min_q == '0 && sec_q == 6'd1) begin
            state_n = ALARM;
            cnt_n   = '0;
          end
        end
      end
      PAUSE: begin
        if (bus.btn_clear) begin
          state_n = IDLE;
          min_n   = '0;
          sec_n   = '0;
        end else if (bus.btn_start) begin
          state_n = RUN;
        end
      end
      ALARM: begin
        if (bus.btn_clear || bus.btn_start) begin
          state_n = IDLE;
          min_n   = '0;
          sec_n   = '0;
          cnt_n   = '0;
        end else if (tick_pulse) begin
          if (cnt_q + 8'd1 == A_TKS) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b1;  // a high tick_in at release is not an edge
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      min_q     <= min_n;
      sec_q     <= sec_n;
      cnt_q     <= cnt_n;
      tick_q    <= bus.tick_in;
      running_q <= (state_n == RUN);
      alarm_q   <= (state_n == ALARM);
    end
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_egg_timer_controller.sv
module tb_egg_timer_controller;
  localparam int MAX_MINUTES = 99;
  localparam int ALARM_TICKS = 10;

  logic clk;
  logic reset;
  egg_timer_if bus();

  egg_timer_controller #(.MAX_MINUTES(MAX_MINUTES), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase as 0..3, time as plain integers.
  int mm, ms, mst, mcnt;
  bit mprev;

  task automatic model_reset();
    mm = 0; ms = 0; mst = 0; mcnt = 0; mprev = 1'b1;
  endtask

  task automatic model_step(input bit t, bm, bs, bst, bc);
    bit pulse;
    int total;
    pulse = t && !mprev;
    mprev = t;
    case (mst)
      0: if (bc) begin mm = 0; ms = 0; end
         else if (bst) begin if (mm * 60 + ms > 0) mst = 1; end
         else begin
           if (bm) mm = (mm + 1) % (MAX_MINUTES + 1);
           if (bs) ms = (ms + 1) % 60;
         end
      1: if (bc) begin mst = 0; mm = 0; ms = 0; end
         else if (bst) mst = 2;
         else if (pulse) begin
           total = mm * 60 + ms - 1;
           mm = total / 60;
           ms = total % 60;
           if (total == 0) begin mst = 3; mcnt = 0; end
         end
      2: if (bc) begin mst = 0; mm = 0; ms = 0; end
         else if (bst) mst = 1;
      default:
         if (bc || bst) begin mst = 0; mcnt = 0; end
         else if (pulse) begin
           mcnt++;
           if (mcnt == ALARM_TICKS) begin mst = 0; mcnt = 0; end
         end
    endcase
  endtask

  task automatic chk(input string name, input int em, es, est);
    int am, as_, ast, ar, aa;
    am = bus.minutes; as_ = bus.seconds; ast = bus.state;
    ar = bus.running; aa = bus.alarm;
    checks++;
    if (am != em || as_ != es || ast != est || ar != int'(est == 1) || aa != int'(est == 3)) begin
      failures++;
      $display("FAIL %s: got %0d:%0d state=%0d running=%0d alarm=%0d, expected %0d:%0d state=%0d running=%0d alarm=%0d",
               name, am, as_, ast, ar, aa, em, es, est, int'(est == 1), int'(est == 3));
    end
  endtask

  // One clock: drive, step model on the edge, compare 1 time unit later.
  task automatic cyc(input bit t, bm, bs, bst, bc);
    bus.tick_in = t; bus.btn_min = bm; bus.btn_sec = bs;
    bus.btn_start = bst; bus.btn_clear = bc;
    @(posedge clk);
    #1;
    model_step(t, bm, bs, bst, bc);
    chk("model", mm, ms, mst);
  endtask

  typedef struct {
    bit t, bm, bs, bst, bc;
    int em, es, est;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 2, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0, 2, 1, 0};
    tbl[3]  = '{1, 0, 1, 0, 0, 2, 2, 0};
    tbl[4]  = '{1, 0, 1, 0, 0, 2, 3, 0};
    tbl[5]  = '{1, 0, 0, 1, 0, 2, 3, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 2, 3, 1};
    tbl[7]  = '{1, 0, 0, 0, 0, 2, 2, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 2, 2, 1};
    tbl[9]  = '{1, 0, 0, 0, 0, 2, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 2, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 2, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 2, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 59, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 0, 0};

    // Reset with tick_in held high across release.
    bus.tick_in = 1; bus.btn_min = 0; bus.btn_sec = 0; bus.btn_start = 0; bus.btn_clear = 0;
    reset = 0;
    model_reset();
    #23;
    chk("reset_state", 0, 0, 0);
    @(negedge clk) reset = 1;
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("release_tick_high", 0, 0, 0);

    // Set 2:03, run, four ticks.
    foreach (tbl[i]) begin
      cyc(tbl[i].t, tbl[i].bm, tbl[i].bs, tbl[i].bst, tbl[i].bc);
      chk($sformatf("vec%0d", i), tbl[i].em, tbl[i].es, tbl[i].est);
    end

    // 0:02 countdown into ALARM and auto-return after ALARM_TICKS ticks.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("alarm_start", 0, 2, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("alarm_enter", 0, 0, 3);
    for (int k = 1; k <= ALARM_TICKS; k++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      if (k == ALARM_TICKS - 1) chk("alarm_hold", 0, 0, 3);
    end
    chk("alarm_timeout", 0, 0, 0);

    // Pause coincident with a tick discards that tick.
    for (int k = 0; k < 30; k++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("pause_tick_drop", 0, 30, 2);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    chk("pause_hold", 0, 30, 2);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("resume_tick", 0, 29, 1);
    cyc(0, 0, 0, 0, 1);
    chk("run_clear", 0, 0, 0);

    // 99:59 wraps to 0:00 on a simultaneous min+sec press; start then ignored.
    for (int k = 0; k < 59; k++) cyc(0, 1, 1, 0, 0);
    for (int k = 0; k < 40; k++) cyc(0, 1, 0, 0, 0);
    chk("set_99_59", 99, 59, 0);
    cyc(0, 1, 1, 0, 0);
    chk("wrap_both", 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("start_at_zero", 0, 0, 0);

    // Asynchronous reset in RUN at 1:00.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("run_1_00", 1, 0, 1);
    #3 reset = 0;
    #1;
    model_reset();
    chk("async_reset", 0, 0, 0);
    @(negedge clk) reset = 1;
    cyc(0, 0, 0, 0, 0);
    chk("after_release", 0, 0, 0);

    // btn_clear in ALARM.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("alarm_from_0_01", 0, 0, 3);
    cyc(0, 0, 0, 0, 1);
    chk("alarm_clear", 0, 0, 0);

    // Randomized traffic against the model.
    begin
      bit t;
      t = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 2) == 0) t = ~t;
        cyc(t, $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
